uart_banner_loader: RTL

Upstream feeder for the banner's BCD shift register. Consumes bytes from the UART receiver and assembles ASCII decimal digits into a W*N-bit frame. On a terminator it presents the frame together with a one-cycle write strobe. Single-letter ASCII commands become one-cycle direction/start/pause strobes that drive the shift register's control inputs directly.

---
 rtl/uart_banner_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_banner_loader.sv
// rtl/uart_banner_loader.sv - assembles UART decimal digits into a banner frame and decodes control letters
module uart_banner_loader #(
  parameter int          W     = 4,
  parameter int          N     = 6,
  parameter logic [3:0]  BLANK = 4'hF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [W*N-1:0] data_out,
  output logic           write,
  output logic           set_left,
  output logic           set_right,
  output logic           start,
  output logic           pause,
  output logic           err
);

  localparam int             IW      = $clog2(N + 1);
  localparam logic [IW-1:0]  IDX_MAX = IW'(N);
  localparam logic [W-1:0]   BLANK_W = W'(BLANK);
  localparam logic [W*N-1:0] FRAME_BLANK = {N{BLANK_W}};

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_L   = 8'h4C;
  localparam logic [7:0] CH_R   = 8'h52;
  localparam logic [7:0] CH_S   = 8'h53;
  localparam logic [7:0] CH_P   = 8'h50;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  idx, idx_nx;
  logic [W*N-1:0] staging, staging_nx;
  logic [W*N-1:0] data_nx;
  logic           write_nx, left_nx, right_nx, start_nx, pause_nx, err_nx;

  // byte classification; clearing bit 5 folds lower-case letters onto upper-case
  logic [7:0] folded;
  logic       is_digit, is_cr, is_esc, is_l, is_r, is_s, is_p;
  logic [W-1:0] digit;
  int           pos;

  // classify the incoming byte and form the zero-extended digit value
  always_comb begin
    folded   = rx_data & 8'hDF;
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_cr    = (rx_data == CH_CR);
    is_esc   = (rx_data == CH_ESC);
    is_l     = (folded == CH_L);
    is_r     = (folded == CH_R);
    is_s     = (folded == CH_S);
    is_p     = (folded == CH_P);
    digit      = '0;
    digit[3:0] = rx_data[3:0];
    // first digit goes to the most-significant position
    pos = N - 1 - int'(idx);
  end

  // next-state, staging and registered-output computation
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    staging_nx = staging;
    data_nx    = data_out;
    write_nx   = 1'b0;
    left_nx    = 1'b0;
    right_nx   = 1'b0;
    start_nx   = 1'b0;
    pause_nx   = 1'b0;
    err_nx     = 1'b0;

    if (rx_valid) begin
      if (is_digit) begin
        if (idx < IDX_MAX) begin
          staging_nx[pos*W +: W] = digit;
          idx_nx                 = idx + 1'b1;
          state_nx               = COLLECT;
        end else begin
          // frame full: drop the digit, keep what was collected
          err_nx = 1'b1;
        end
      end else if (is_cr) begin
        // an empty frame is never committed
        if (state == COLLECT) begin
          data_nx    = staging;
          write_nx   = 1'b1;
          staging_nx = FRAME_BLANK;
          idx_nx     = '0;
          state_nx   = IDLE;
        end
      end else if (is_esc) begin
        staging_nx = FRAME_BLANK;
        idx_nx     = '0;
        state_nx   = IDLE;
      end else if (is_l) begin
        left_nx = 1'b1;
      end else if (is_r) begin
        right_nx = 1'b1;
      end else if (is_s) begin
        start_nx = 1'b1;
      end else if (is_p) begin
        pause_nx = 1'b1;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  // state register and registered outputs; reset discards any partial frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      staging   <= FRAME_BLANK;
      data_out  <= '0;
      write     <= 1'b0;
      set_left  <= 1'b0;
      set_right <= 1'b0;
      start     <= 1'b0;
      pause     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      staging   <= staging_nx;
      data_out  <= data_nx;
      write     <= write_nx;
      set_left  <= left_nx;
      set_right <= right_nx;
      start     <= start_nx;
      pause     <= pause_nx;
      err       <= err_nx;
    end
  end

endmodule
